decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Pipelined RV32I/RV64I instruction decode stage. It sits between fetch and execute and turns raw 32-bit instructions into t_decoded_instr. It generalises the existing decoded-instruction format in three ways: XLEN-wide immediates, an added register-register OP kind, and a valid/ready handshake with a 2-entry skid buffer and flush.

Parameters:
XLEN, 32, datapath width (32 or 64); immediates and PC are sign-extended to XLEN.
SHAMT_W, $clog2(XLEN), width of the shift-amount field taken from instr[SHAMT_W+19:20].

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  reset, synchronous, active-low.
flush  input  1  discard all buffered entries.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage can accept this cycle.
in_instr  input  32  raw instruction.
in_pc  input  XLEN  instruction address.
out_valid  output  1  decoded entry available.
out_ready  input  1  execute accepts the entry.
out_decoded  output  $bits(t_decoded_instr)  decoded instruction.
out_pc  output  XLEN  PC of the entry.
out_auipc_result  output  XLEN  pc+imm; meaningful only when kind=OK_OP_AUIPC.
out_illegal  output  1  entry failed decode (DECODE_ILLEGAL_EN only; otherwise tied 0).

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, in_ready=1, both entries empty. Data outputs read 0 while out_valid=0.
- Transfer rule: input fires when in_valid&in_ready; output fires when out_valid&out_ready.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N; decode logic sits before the main register.
- Storage: main register plus skid register, 2 entries total.
  - in_ready = !skid_full, registered with no combinational path from out_ready.
  - When the main register is full and out_ready=0, a newly accepted entry goes to the skid register.
  - On output fire, skid moves to main.
  - Simultaneous input fire and output fire with one entry held: the new entry replaces main, and occupancy is unchanged.
  - Order is always preserved.
- Flush is synchronous and takes priority. At the edge: both entries are emptied, any input in the same cycle is dropped, and the next cycle has out_valid=0, in_ready=1. Reset beats flush.
- Decode, by opcode in[6:0]:
  - OP_IMM (0010011): func from funct3.
    - funct3 101: SRA if instr[30], else SRL.
    - Shifts: imm = zero-extended shamt.
    - Others: imm = sign-extended instr[31:20].
    - rd = [11:7], rs1 = [19:15].
  - OP (0110011): funct3 plus instr[30] select ADD/SUB and SRL/SRA. rd, rs1 and rs2 ([24:20]) are all populated.
  - LUI (0110111): imm = sign-extend({instr[31:12],12'b0}); rd.
  - AUIPC (0010111): imm as LUI. out_auipc_result = pc+imm, computed before the register, modulo 2^XLEN.
  - Anything else: kind = OK_UNKNOWN and the instr_data payload is all zeros.
- Unused union bits are 0. The decoded payload must never carry X.

Optional Feature:
DECODE_ILLEGAL_EN.
- Defined: out_illegal=1 with the entry for any of the following:
  - unknown opcode;
  - OP with funct7 other than 0000000/0100000 (0100000 is allowed only with funct3 000/101);
  - shift-immediate with a non-zero upper field (RV32: instr[31:25] ∉ {0000000, 0100000 for SRAI only});
  - low two bits ≠ 11.
  Kind is then forced to OK_UNKNOWN.
- Undefined: out_illegal is constant 0; unknown opcodes still give OK_UNKNOWN and no other checks exist.

Decomposition:
- Shared Types package:
  - t_op_kind widened to 3 bits with OK_OP_REG added;
  - OP_REG opcode constant;
  - t_op_reg_instr (func, rs1, rs2, rd);
  - XLEN-parametrised word via a package-level localparam XLEN default 32;
  - padding computed with $bits as today.
- Sub-module: instr_decode, purely combinational (instr, pc → decoded, auipc_result, illegal). decode_stage holds the skid logic and the registers.

Test Plan:
- ADDI x1,x0,-1 = 0xFFF00093, out_ready=1 → one cycle later: kind OP_IMM, FK_ADD, rd 1, rs1 0, imm 0xFFFFFFFF.
- LUI x5,0x12345 = 0x123452B7 → kind OP_LUI, rd 5, imm 0x12345000. AUIPC x3,1 = 0x00001197 at pc 0x100 → out_auipc_result 0x00001100.
- SRAI x2,x2,3 = 0x40315113 → FK_SRA, imm 3. SUB x3,x1,x2 = 0x402081B3 → OK_OP_REG, FK_SUB, rs1 1, rs2 2, rd 3.
- Four back-to-back valid instructions with out_ready=0 for 3 cycles → in_ready falls after 2 accepted. On release, all 4 emerge in order with no loss or duplication.
- Two entries held, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
- 0xFFFFFFFF with DECODE_ILLEGAL_EN → OK_UNKNOWN, out_illegal=1. Without the macro → OK_UNKNOWN, out_illegal=0. rst_n=0 mid-stream → all buffered entries lost, outputs at reset values.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode types: decoded-instruction format, opcode constants and ALU function mapping.
// Type widths follow the package XLEN; instances must use the same value.
package decode_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] t_word;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP_REG = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        OK_UNKNOWN  = 3'd0,
        OK_OP_IMM   = 3'd1,
        OK_OP_LUI   = 3'd2,
        OK_OP_AUIPC = 3'd3,
        OK_OP_REG   = 3'd4
    } t_op_kind;

    typedef enum logic [3:0] {
        FK_ADD, FK_SUB, FK_SLL, FK_SLT, FK_SLTU,
        FK_XOR, FK_SRL, FK_SRA, FK_OR, FK_AND
    } t_func;

    typedef struct packed {
        t_func       func;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        t_word       imm;
    } t_op_imm_instr;

    // The widest view sets the payload width; the others pad up to it.
    localparam int PAYLOAD_W = $bits(t_op_imm_instr);
    localparam int U_PAD_W   = PAYLOAD_W - $bits(t_word) - 5;
    localparam int R_PAD_W   = PAYLOAD_W - $bits(t_func) - 15;

    typedef struct packed {
        logic [U_PAD_W-1:0] pad;
        logic [4:0]         rd;
        t_word              imm;
    } t_u_instr;

    typedef struct packed {
        logic [R_PAD_W-1:0] pad;
        t_func              func;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
    } t_op_reg_instr;

    typedef union packed {
        t_op_imm_instr op_imm;
        t_u_instr      lui;
        t_u_instr      auipc;
        t_op_reg_instr op_reg;
    } t_instr_data;

    typedef struct packed {
        t_op_kind    kind;
        t_instr_data instr_data;
    } t_decoded_instr;

    typedef struct packed {
        t_decoded_instr dec;
        t_word          pc;
        t_word          auipc;
        logic           illegal;
    } t_entry;

    // alt is instr[30]; it only distinguishes ADD/SUB and SRL/SRA.
    function automatic t_func alu_func(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  alu_func = alt ? FK_SUB : FK_ADD;
            3'b001:  alu_func = FK_SLL;
            3'b010:  alu_func = FK_SLT;
            3'b011:  alu_func = FK_SLTU;
            3'b100:  alu_func = FK_XOR;
            3'b101:  alu_func = alt ? FK_SRA : FK_SRL;
            3'b110:  alu_func = FK_OR;
            default: alu_func = FK_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_if #(
    parameter int XLEN = decode_stage_pkg::XLEN
);
    import decode_stage_pkg::*;

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    t_decoded_instr  out_decoded;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_auipc_result;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_decoded, out_pc, out_auipc_result, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_decoded, out_pc, out_auipc_result, out_illegal
    );

endinterface

// File: rtl/decode_stage_instr_decode.sv
// Combinational RV32I/RV64I decoder for OP_IMM, OP, LUI and AUIPC.
// DECODE_ILLEGAL_EN adds encoding checks that force illegal entries to OK_UNKNOWN.
module instr_decode
    import decode_stage_pkg::*;
#(
    parameter int XLEN    = decode_stage_pkg::XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output t_decoded_instr  decoded_o,
    output logic [XLEN-1:0] auipc_result_o,
    output logic            illegal_o
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] auipc_sum;
    t_decoded_instr  dec;

    assign opcode   = instr_i[6:0];
    assign funct3   = instr_i[14:12];
    assign is_shift = (funct3[1:0] == 2'b01);
    assign imm_i    = XLEN'($signed(instr_i[31:20]));
    assign imm_u    = XLEN'($signed({instr_i[31:12], 12'b0}));
    assign shamt    = XLEN'(instr_i[SHAMT_W+19:20]);

    always_comb begin
        dec       = '0;
        auipc_sum = '0;
        case (opcode)
            OPC_OP_IMM: begin
                dec.kind                   = OK_OP_IMM;
                dec.instr_data.op_imm.func = alu_func(funct3, is_shift & instr_i[30]);
                dec.instr_data.op_imm.rs1  = instr_i[19:15];
                dec.instr_data.op_imm.rd   = instr_i[11:7];
                dec.instr_data.op_imm.imm  = is_shift ? shamt : imm_i;
            end
            OPC_OP_REG: begin
                dec.kind                   = OK_OP_REG;
                dec.instr_data.op_reg.func = alu_func(funct3, instr_i[30]);
                dec.instr_data.op_reg.rs1  = instr_i[19:15];
                dec.instr_data.op_reg.rs2  = instr_i[24:20];
                dec.instr_data.op_reg.rd   = instr_i[11:7];
            end
            OPC_LUI: begin
                dec.kind                = OK_OP_LUI;
                dec.instr_data.lui.rd   = instr_i[11:7];
                dec.instr_data.lui.imm  = imm_u;
            end
            OPC_AUIPC: begin
                dec.kind                 = OK_OP_AUIPC;
                dec.instr_data.auipc.rd  = instr_i[11:7];
                dec.instr_data.auipc.imm = imm_u;
                auipc_sum                = pc_i + imm_u;
            end
            default: ;
        endcase
    end

`ifdef DECODE_ILLEGAL_EN
    logic [6:0] funct7;
    logic       known;
    logic       bad_shift;
    logic       bad_op;

    assign funct7    = instr_i[31:25];
    assign known     = opcode inside {OPC_OP_IMM, OPC_OP_REG, OPC_LUI, OPC_AUIPC};
    // Above the shamt only instr[30] may be set, and only for SRAI.
    assign bad_shift = (opcode == OPC_OP_IMM) && is_shift &&
                       (instr_i[31] || (|instr_i[29:SHAMT_W+20]) ||
                        (instr_i[30] && funct3 != 3'b101));
    assign bad_op    = (opcode == OPC_OP_REG) &&
                       !(funct7 == 7'b0000000 ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
    assign illegal_o      = !known || bad_shift || bad_op || (instr_i[1:0] != 2'b11);
    assign decoded_o      = illegal_o ? '0 : dec;
    assign auipc_result_o = illegal_o ? '0 : auipc_sum;
`else
    assign illegal_o      = 1'b0;
    assign decoded_o      = dec;
    assign auipc_result_o = auipc_sum;
`endif

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decoder feeding a main register backed by a skid register.
// DECODE_ILLEGAL_EN enables the illegal-encoding flag on out_illegal.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN    = decode_stage_pkg::XLEN,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    t_entry          main_q, main_d, skid_q, skid_d, new_e;
    logic            main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic            in_fire, out_fire;
    t_decoded_instr  dec;
    logic [XLEN-1:0] auipc;
    logic            illegal;

    instr_decode #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_decode (
        .instr_i        (bus.in_instr),
        .pc_i           (bus.in_pc),
        .decoded_o      (dec),
        .auipc_result_o (auipc),
        .illegal_o      (illegal)
    );

    assign new_e    = {dec, bus.in_pc, auipc, illegal};
    assign in_fire  = bus.in_valid && !skid_vld_q;
    assign out_fire = main_vld_q && bus.out_ready;

    // The skid only fills while main is held, so occupancy 2 <=> skid full.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (out_fire) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = in_fire;
                if (in_fire) main_d = new_e;
            end
        end else if (in_fire) begin
            if (main_vld_q) begin
                skid_d     = new_e;
                skid_vld_d = 1'b1;
            end else begin
                main_d     = new_e;
                main_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign bus.in_ready         = !skid_vld_q;
    assign bus.out_valid        = main_vld_q;
    assign bus.out_decoded      = main_vld_q ? main_q.dec     : '0;
    assign bus.out_pc           = main_vld_q ? main_q.pc      : '0;
    assign bus.out_auipc_result = main_vld_q ? main_q.auipc   : '0;
    assign bus.out_illegal      = main_vld_q ? main_q.illegal : 1'b0;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus random traffic against a queue model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    typedef struct packed {
        t_decoded_instr dec;
        logic [31:0]    pc;
        logic [31:0]    auipc;
        logic           ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if bus ();
    decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    t_decoded_instr od;
    assign od = bus.out_decoded;

    exp_t        q[$];
    logic [31:0] got_pcs[$];
    logic [31:0] prev_pc = '0;
    bit          ifire, ofire;
    int          checks = 0, errors = 0, n_relaxed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA encoding rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        t_func       ftab [8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] uimm;
        logic        ill;
        ftab = '{FK_ADD, FK_SLL, FK_SLT, FK_SLTU, FK_XOR, FK_SRL, FK_OR, FK_AND};
        e    = '0;
        e.pc = pc;
        f3   = ins[14:12];
        f7   = ins[31:25];
        uimm = ins & 32'hFFFF_F000;
        ill  = 1'b0;
        case (ins[6:0])
            7'h13: begin
                e.dec.kind = OK_OP_IMM;
                e.dec.instr_data.op_imm.func = (f3 == 3'd5 && ins[30]) ? FK_SRA : ftab[f3];
                e.dec.instr_data.op_imm.rd   = ins[11:7];
                e.dec.instr_data.op_imm.rs1  = ins[19:15];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.dec.instr_data.op_imm.imm = {27'b0, ins[24:20]};
                    ill = !(f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20));
                end else begin
                    e.dec.instr_data.op_imm.imm = $signed(ins) >>> 20;
                end
            end
            7'h33: begin
                e.dec.kind = OK_OP_REG;
                e.dec.instr_data.op_reg.func = ftab[f3];
                if (ins[30] && f3 == 3'd0) e.dec.instr_data.op_reg.func = FK_SUB;
                if (ins[30] && f3 == 3'd5) e.dec.instr_data.op_reg.func = FK_SRA;
                e.dec.instr_data.op_reg.rd  = ins[11:7];
                e.dec.instr_data.op_reg.rs1 = ins[19:15];
                e.dec.instr_data.op_reg.rs2 = ins[24:20];
                ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            7'h37: begin
                e.dec.kind = OK_OP_LUI;
                e.dec.instr_data.lui.rd  = ins[11:7];
                e.dec.instr_data.lui.imm = uimm;
            end
            7'h17: begin
                e.dec.kind = OK_OP_AUIPC;
                e.dec.instr_data.auipc.rd  = ins[11:7];
                e.dec.instr_data.auipc.imm = uimm;
                e.auipc = pc + uimm;
            end
            default: ill = 1'b1;
        endcase
`ifdef DECODE_ILLEGAL_EN
        if (ins[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            e.dec   = '0;
            e.auipc = '0;
            e.ill   = 1'b1;
        end
`else
        if (ill) n_relaxed++;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 5);
        case (k)
            0, 1:    r[6:0] = 7'h13;
            2:       r[6:0] = 7'h33;
            3:       r[6:0] = 7'h37;
            4:       r[6:0] = 7'h17;
            default: ;
        endcase
        if ((r[6:0] == 7'h13 || r[6:0] == 7'h33) && $urandom_range(0, 3) != 0)
            r[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic check_outputs();
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("in_ready", bus.in_ready, q.size() < 2);
        if (q.size() != 0) begin
            chk("decoded", od, q[0].dec);
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("auipc", bus.out_auipc_result, q[0].auipc);
            chk("illegal", bus.out_illegal, q[0].ill);
        end else begin
            chk("idle_decoded", od, '0);
            chk("idle_pc", bus.out_pc, '0);
            chk("idle_auipc", bus.out_auipc_result, '0);
            chk("idle_illegal", bus.out_illegal, '0);
        end
        prev_pc = bus.out_pc;
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic cyc();
        @(posedge clk);
        ifire = 1'b0;
        ofire = 1'b0;
        if (!rst_n || bus.flush) begin
            q.delete();
        end else begin
            ofire = (q.size() != 0) && bus.out_ready;
            ifire = bus.in_valid && (q.size() < 2);
            if (ofire) begin
                void'(q.pop_front());
                got_pcs.push_back(prev_pc);
            end
            if (ifire) q.push_back(model(bus.in_instr, bus.in_pc));
        end
        #1;
        check_outputs();
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int idx;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0;
        bus.in_pc = '0;   bus.out_ready = 1'b0;
        rst_n = 1'b0;
        idle(2);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;

        send(32'hFFF0_0093, 32'h0000_1000);
        chk("addi_kind", od.kind, OK_OP_IMM);
        chk("addi_func", od.instr_data.op_imm.func, FK_ADD);
        chk("addi_rd", od.instr_data.op_imm.rd, 5'd1);
        chk("addi_rs1", od.instr_data.op_imm.rs1, 5'd0);
        chk("addi_imm", od.instr_data.op_imm.imm, 32'hFFFF_FFFF);
        send(32'h1234_52B7, 32'h0000_1004);
        chk("lui_kind", od.kind, OK_OP_LUI);
        chk("lui_rd", od.instr_data.lui.rd, 5'd5);
        chk("lui_imm", od.instr_data.lui.imm, 32'h1234_5000);
        send(32'h0000_1197, 32'h0000_0100);
        chk("auipc_kind", od.kind, OK_OP_AUIPC);
        chk("auipc_result", bus.out_auipc_result, 32'h0000_1100);
        send(32'h4031_5113, 32'h0000_0104);
        chk("srai_func", od.instr_data.op_imm.func, FK_SRA);
        chk("srai_imm", od.instr_data.op_imm.imm, 32'd3);
        send(32'h4020_81B3, 32'h0000_0108);
        chk("sub_kind", od.kind, OK_OP_REG);
        chk("sub_func", od.instr_data.op_reg.func, FK_SUB);
        chk("sub_rs1", od.instr_data.op_reg.rs1, 5'd1);
        chk("sub_rs2", od.instr_data.op_reg.rs2, 5'd2);
        chk("sub_rd", od.instr_data.op_reg.rd, 5'd3);
        send(32'hFFFF_FFFF, 32'h0000_010C);
        chk("unk_kind", od.kind, OK_UNKNOWN);
        chk("unk_payload", od.instr_data, '0);
`ifdef DECODE_ILLEGAL_EN
        chk("unk_illegal", bus.out_illegal, 1'b1);
`else
        chk("unk_illegal", bus.out_illegal, 1'b0);
`endif
        idle(2);

        // Four back-to-back instructions against three cycles of backpressure.
        got_pcs.delete();
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && (idx < 4 || q.size() != 0); c++) begin
            if (c == 3) bus.out_ready = 1'b1;
            bus.in_valid = (idx < 4);
            bus.in_instr = 32'h0000_0013 | (32'(idx + 1) << 7);
            bus.in_pc    = 32'h0000_0200 + 32'(idx * 4);
            cyc();
            if (ifire) idx++;
            if (c == 1) chk("bp_in_ready_low", bus.in_ready, 1'b0);
        end
        bus.in_valid = 1'b0;
        chk("bp_count", got_pcs.size(), 4);
        for (int i = 0; i < 4 && i < got_pcs.size(); i++)
            chk("bp_order", got_pcs[i], 32'h0000_0200 + 32'(i * 4));

        // Flush with two entries held and a new instruction offered.
        bus.out_ready = 1'b0;
        send(32'h0010_0093, 32'h0000_0300);
        send(32'h0020_0093, 32'h0000_0304);
        bus.flush = 1'b1;
        send(32'h0030_0093, 32'h0000_0308);
        bus.flush = 1'b0;
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("flush_quiet", bus.out_valid, 1'b0);
        end

        // Reset mid-stream drops buffered entries.
        bus.out_ready = 1'b0;
        send(32'h0040_0093, 32'h0000_0400);
        send(32'h0050_0093, 32'h0000_0404);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk("rst_mid_pc", bus.out_pc, '0);
        bus.out_ready = 1'b1;
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_instr  = rand_instr();
            bus.in_pc     = $urandom & 32'hFFFF_FFFC;
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 39) == 0);
            rst_n         = ($urandom_range(0, 299) != 0);
            cyc();
        end
        bus.in_valid = 1'b0; bus.flush = 1'b0; rst_n = 1'b1; bus.out_ready = 1'b1;
        idle(3);

`ifndef DECODE_ILLEGAL_EN
        $display("info: relaxed-decode encodings seen %0d", n_relaxed);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
